// File: rtl/rgb2gray_pkg.sv
// rgb2gray_pkg
// Shared definitions for the grayscale conversion stage: the weighting
// mode enum, the per-mode channel weights and the rounding constant.
// No ports (package).
package rgb2gray_pkg;

    typedef enum logic [1:0] {
        MODE_BT601 = 2'd0,
        MODE_BT709 = 2'd1,
        MODE_AVG   = 2'd2,
        MODE_GREEN = 2'd3
    } mode_t;

    // Weights are fractions of 256. The green-only weight is exactly 256,
    // so each weight needs 9 bits.
    localparam int WEIGHT_W = 9;

    typedef struct packed {
        logic [WEIGHT_W-1:0] r;
        logic [WEIGHT_W-1:0] g;
        logic [WEIGHT_W-1:0] b;
    } weights_t;

    localparam weights_t W_BT601 = '{r: 9'd77, g: 9'd150, b: 9'd29};
    localparam weights_t W_BT709 = '{r: 9'd54, g: 9'd183, b: 9'd19};
    localparam weights_t W_AVG   = '{r: 9'd85, g: 9'd85,  b: 9'd86};
    localparam weights_t W_GREEN = '{r: 9'd0,  g: 9'd256, b: 9'd0};

    // Half of the 256 weight scale, added before dropping the 8 fraction bits.
    localparam int ROUND_CONST = 128;

    function automatic weights_t mode_weights(input mode_t mode);
        weights_t w;
        case (mode)
            MODE_BT601: w = W_BT601;
            MODE_BT709: w = W_BT709;
            MODE_AVG:   w = W_AVG;
            MODE_GREEN: w = W_GREEN;
            default:    w = W_BT601;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rgb2gray_stats_frame_stats.sv
// frame_stats
// Per-frame gray statistics: running min, max, saturating sum and
// saturating pixel count, with an overflow flag. When the delayed frame
// valid falls, the running values are copied to the stat registers,
// stat_valid pulses for one cycle and the accumulators restart.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   gray                  pipeline output gray value
//   dval, fval            data/frame valid aligned with gray
//   stat_min, stat_max    last frame min/max gray
//   stat_sum, stat_count  last frame gray sum and pixel count
//   stat_ovf              sum or count saturated in last frame
//   stat_valid            one-cycle pulse when stats update
module frame_stats #(
    parameter int OUT_W = 8,
    parameter int CNT_W = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OUT_W-1:0]       gray,
    input  logic                   dval,
    input  logic                   fval,
    output logic [OUT_W-1:0]       stat_min,
    output logic [OUT_W-1:0]       stat_max,
    output logic [CNT_W+OUT_W-1:0] stat_sum,
    output logic [CNT_W-1:0]       stat_count,
    output logic                   stat_ovf,
    output logic                   stat_valid
);

    localparam int SUM_W = CNT_W + OUT_W;

    logic             fval_prev;
    logic [OUT_W-1:0] acc_min;
    logic [OUT_W-1:0] acc_max;
    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] acc_count;
    logic             acc_ovf;

    logic             frame_end;
    logic             counted;
    logic [SUM_W:0]   sum_next;
    logic [CNT_W:0]   count_next;

    // One extra bit on the sum/count adders exposes the carry used for saturation.
    always_comb begin
        frame_end  = fval_prev & ~fval;
        counted    = dval & fval;
        sum_next   = {1'b0, acc_sum} + (SUM_W+1)'(gray);
        count_next = {1'b0, acc_count} + (CNT_W+1)'(1);
    end

    // Frame end takes priority: no counted pixel can coincide with it because
    // fval is low on that cycle, so reinitialising here never drops a pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            fval_prev  <= 1'b0;
            acc_min    <= '1;
            acc_max    <= '0;
            acc_sum    <= '0;
            acc_count  <= '0;
            acc_ovf    <= 1'b0;
            stat_min   <= '0;
            stat_max   <= '0;
            stat_sum   <= '0;
            stat_count <= '0;
            stat_ovf   <= 1'b0;
            stat_valid <= 1'b0;
        end else begin
            fval_prev  <= fval;
            stat_valid <= 1'b0;
            if (frame_end) begin
                stat_min   <= acc_min;
                stat_max   <= acc_max;
                stat_sum   <= acc_sum;
                stat_count <= acc_count;
                stat_ovf   <= acc_ovf;
                stat_valid <= 1'b1;
                acc_min    <= '1;
                acc_max    <= '0;
                acc_sum    <= '0;
                acc_count  <= '0;
                acc_ovf    <= 1'b0;
            end else if (counted) begin
                if (gray < acc_min) acc_min <= gray;
                if (gray > acc_max) acc_max <= gray;
                acc_sum   <= sum_next[SUM_W] ? '1 : sum_next[SUM_W-1:0];
                acc_count <= count_next[CNT_W] ? '1 : count_next[CNT_W-1:0];
                acc_ovf   <= acc_ovf | sum_next[SUM_W] | count_next[CNT_W];
            end
        end
    end

endmodule

// File: rtl/rgb2gray_stats.sv
// rgb2gray_stats
// RGB to gray converter with per-frame statistics. Weighting mode is
// latched at each frame start; gray comes out through a fixed 3-stage
// pipeline (products, rounded sum, extract) alongside delayed valids
// and coordinates. Statistics are gathered by frame_stats on the
// pipeline output.
// Ports:
//   iCLK, iReset               clock, synchronous active-high reset
//   iMode                      weighting mode, sampled at frame start
//   iRed, iGreen, iBlue        input colour channels
//   iDval, iFval               pixel / frame valid
//   iX_Cont, iY_Cont           pixel coordinates
//   oGray, oDval               gray pixel and its valid (3 cycles later)
//   oX_Cont, oY_Cont           delayed coordinates
//   oMin, oMax, oSum, oCount   last frame statistics
//   oStatOvf, oStatVal         saturation flag, stats-updated pulse
module rgb2gray_stats #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8,
    parameter int CNT_W = 20
) (
    input  logic                   iCLK,
    input  logic                   iReset,
    input  logic [1:0]             iMode,
    input  logic [IN_W-1:0]        iRed,
    input  logic [IN_W-1:0]        iGreen,
    input  logic [IN_W-1:0]        iBlue,
    input  logic                   iDval,
    input  logic                   iFval,
    input  logic [15:0]            iX_Cont,
    input  logic [15:0]            iY_Cont,
    output logic [OUT_W-1:0]       oGray,
    output logic                   oDval,
    output logic [15:0]            oX_Cont,
    output logic [15:0]            oY_Cont,
    output logic [OUT_W-1:0]       oMin,
    output logic [OUT_W-1:0]       oMax,
    output logic [CNT_W+OUT_W-1:0] oSum,
    output logic [CNT_W-1:0]       oCount,
    output logic                   oStatOvf,
    output logic                   oStatVal
);

    import rgb2gray_pkg::*;

    // Product width leaves headroom for the 9-bit weight; the rounded sum
    // of all three products always fits since weights total 256.
    localparam int PW    = IN_W + WEIGHT_W;
    localparam int SHIFT = 8 + IN_W - OUT_W;

    logic     fval_prev;
    mode_t    mode_reg;
    mode_t    mode_eff;
    weights_t w;

    logic [PW-1:0] prod_r, prod_g, prod_b;
    logic          dval_s1, fval_s1;
    logic [15:0]   x_s1, y_s1;

    logic [PW-1:0] sum_s2;
    logic          dval_s2, fval_s2;
    logic [15:0]   x_s2, y_s2;

    logic          fval_d3;

    // A frame-valid rise lets the incoming mode steer the very pixel that
    // arrives with it; otherwise the latched mode holds for the frame.
    always_comb begin
        mode_eff = mode_reg;
        if (iFval && !fval_prev) mode_eff = mode_t'(iMode);
        w = mode_weights(mode_eff);
    end

    always_ff @(posedge iCLK) begin
        if (iReset) begin
            fval_prev <= 1'b0;
            mode_reg  <= MODE_BT601;
        end else begin
            fval_prev <= iFval;
            mode_reg  <= mode_eff;
        end
    end

    // Three-stage datapath: weighted products, rounded sum, MSB extract.
    always_ff @(posedge iCLK) begin
        if (iReset) begin
            prod_r  <= '0;
            prod_g  <= '0;
            prod_b  <= '0;
            dval_s1 <= 1'b0;
            fval_s1 <= 1'b0;
            x_s1    <= '0;
            y_s1    <= '0;
            sum_s2  <= '0;
            dval_s2 <= 1'b0;
            fval_s2 <= 1'b0;
            x_s2    <= '0;
            y_s2    <= '0;
            oGray   <= '0;
            oDval   <= 1'b0;
            fval_d3 <= 1'b0;
            oX_Cont <= '0;
            oY_Cont <= '0;
        end else begin
            prod_r  <= PW'(w.r) * PW'(iRed);
            prod_g  <= PW'(w.g) * PW'(iGreen);
            prod_b  <= PW'(w.b) * PW'(iBlue);
            dval_s1 <= iDval;
            fval_s1 <= iFval;
            x_s1    <= iX_Cont;
            y_s1    <= iY_Cont;

            sum_s2  <= prod_r + prod_g + prod_b + PW'(ROUND_CONST);
            dval_s2 <= dval_s1;
            fval_s2 <= fval_s1;
            x_s2    <= x_s1;
            y_s2    <= y_s1;

            // Drops the 8 fraction bits and the low IN_W-OUT_W gray bits at once.
            oGray   <= OUT_W'(sum_s2 >> SHIFT);
            oDval   <= dval_s2;
            fval_d3 <= fval_s2;
            oX_Cont <= x_s2;
            oY_Cont <= y_s2;
        end
    end

    frame_stats #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_frame_stats (
        .clk        (iCLK),
        .reset      (iReset),
        .gray       (oGray),
        .dval       (oDval),
        .fval       (fval_d3),
        .stat_min   (oMin),
        .stat_max   (oMax),
        .stat_sum   (oSum),
        .stat_count (oCount),
        .stat_ovf   (oStatOvf),
        .stat_valid (oStatVal)
    );

endmodule

// File: tb/tb_rgb2gray_stats.sv
// tb_rgb2gray_stats
// Self-checking bench for rgb2gray_stats. A stimulus list (directed
// scenarios plus random frames) is driven one entry per clock; a
// frame-level reference model predicts every output cycle.
module tb_rgb2gray_stats;

    localparam int IN_W  = 12;
    localparam int OUT_W = 8;
    localparam int CNT_W = 20;
    localparam int DEPTH = 4096;

    logic                   iCLK;
    logic                   iReset;
    logic [1:0]             iMode;
    logic [IN_W-1:0]        iRed, iGreen, iBlue;
    logic                   iDval, iFval;
    logic [15:0]            iX_Cont, iY_Cont;
    logic [OUT_W-1:0]       oGray;
    logic                   oDval;
    logic [15:0]            oX_Cont, oY_Cont;
    logic [OUT_W-1:0]       oMin, oMax;
    logic [CNT_W+OUT_W-1:0] oSum;
    logic [CNT_W-1:0]       oCount;
    logic                   oStatOvf, oStatVal;

    rgb2gray_stats #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .iCLK(iCLK), .iReset(iReset), .iMode(iMode),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iDval(iDval), .iFval(iFval), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .oGray(oGray), .oDval(oDval), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
        .oMin(oMin), .oMax(oMax), .oSum(oSum), .oCount(oCount),
        .oStatOvf(oStatOvf), .oStatVal(oStatVal)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    typedef struct {
        bit        rst;
        bit        fval;
        bit        dval;
        bit [1:0]  mode;
        bit [11:0] r, g, b;
        bit [15:0] x, y;
    } stim_t;

    typedef struct {
        int     due;
        int     mn, mx;
        longint sum;
        longint cnt;
        bit     ovf;
    } stats_t;

    stim_t  stim[$];
    stats_t pend[$];

    int      numChecks = 0;
    int      numFails  = 0;

    int      expGray   [DEPTH];
    bit      expGrayChk[DEPTH];
    bit      expDval   [DEPTH];
    int      expX      [DEPTH];
    int      expY      [DEPTH];

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t e);
        iReset  = e.rst;
        iFval   = e.fval;
        iDval   = e.dval;
        iMode   = e.mode;
        iRed    = e.r;
        iGreen  = e.g;
        iBlue   = e.b;
        iX_Cont = e.x;
        iY_Cont = e.y;
    endtask

    task automatic pushEntry(input bit rst, input bit fv, input bit dv, input int mode,
                             input int r, input int g, input int b);
        stim_t e;
        e.rst  = rst;
        e.fval = fv;
        e.dval = dv;
        e.mode = 2'(mode);
        e.r    = 12'(r);
        e.g    = 12'(g);
        e.b    = 12'(b);
        e.x    = 16'($urandom_range(0, 65535));
        e.y    = 16'($urandom_range(0, 65535));
        stim.push_back(e);
    endtask

    task automatic pushIdle(input int n);
        for (int i = 0; i < n; i++) pushEntry(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int rnd12();
        return int'($urandom_range(0, 4095));
    endfunction

    // Gray from the weighting rules: weighted sum, round to integer, keep MSBs.
    function automatic int refGray(input int mode, input int r, input int g, input int b);
        int wr, wg, wb, full;
        case (mode)
            0:       begin wr = 77; wg = 150; wb = 29; end
            1:       begin wr = 54; wg = 183; wb = 19; end
            2:       begin wr = 85; wg = 85;  wb = 86; end
            default: begin wr = 0;  wg = 256; wb = 0;  end
        endcase
        full = (wr * r + wg * g + wb * b + 128) / 256;
        return full / (1 << (IN_W - OUT_W));
    endfunction

    task automatic buildStimulus();
        int len, gap;
        // power-up reset
        pushEntry(1, 0, 0, 0, 0, 0, 0);
        pushEntry(1, 0, 0, 0, 0, 0, 0);
        pushIdle(3);
        // BT.601: white and pure red
        pushEntry(0, 1, 1, 0, 4095, 4095, 4095);
        pushEntry(0, 1, 0, 0, 0, 0, 0);
        pushEntry(0, 1, 1, 0, 4095, 0, 0);
        pushIdle(2);
        // green-only
        pushEntry(0, 1, 1, 3, 'hFFF, 'hABC, 'hFFF);
        pushEntry(0, 1, 1, 3, rnd12(), rnd12(), rnd12());
        pushIdle(1);
        // mode change mid-frame is ignored, next frame uses average
        pushEntry(0, 1, 1, 0, 4095, 0, 0);
        pushEntry(0, 1, 1, 2, 4095, 0, 0);
        pushEntry(0, 1, 1, 2, 4095, 0, 0);
        pushIdle(1);
        pushEntry(0, 1, 1, 2, 4095, 0, 0);
        pushEntry(0, 1, 1, 0, 4095, 0, 0);
        pushIdle(2);
        // four-pixel frame with gray 10..40
        for (int v = 10; v <= 40; v += 10) pushEntry(0, 1, 1, 3, rnd12(), v << 4, rnd12());
        pushIdle(6);
        // empty frame
        for (int i = 0; i < 3; i++) pushEntry(0, 1, 0, 1, rnd12(), rnd12(), rnd12());
        pushIdle(6);
        // pixel outside any frame
        pushEntry(0, 0, 1, 1, rnd12(), rnd12(), rnd12());
        pushIdle(4);
        // reset mid-frame with iFval held high
        for (int i = 0; i < 3; i++) pushEntry(0, 1, 1, 1, rnd12(), rnd12(), rnd12());
        pushEntry(1, 1, 1, 1, rnd12(), rnd12(), rnd12());
        for (int i = 0; i < 3; i++) pushEntry(0, 1, 1, 2, rnd12(), rnd12(), rnd12());
        pushIdle(6);
        // random frames, back-to-back gaps, random mid-frame mode values
        for (int f = 0; f < 8; f++) begin
            len = int'($urandom_range(1, 16));
            for (int i = 0; i < len; i++)
                pushEntry(0, 1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                          rnd12(), rnd12(), rnd12());
            gap = int'($urandom_range(1, 3));
            for (int i = 0; i < gap; i++)
                pushEntry(0, 0, $urandom_range(0, 1) != 0, int'($urandom_range(0, 3)),
                          rnd12(), rnd12(), rnd12());
        end
        pushIdle(8);
    endtask

    initial begin
        stim_t  e;
        stats_t acc;
        stats_t held;
        bit     prevFval;
        int     modeReg;
        int     g;
        bit     expSv;

        iReset = 1'b1; iFval = 1'b0; iDval = 1'b0; iMode = 2'd0;
        iRed = '0; iGreen = '0; iBlue = '0; iX_Cont = '0; iY_Cont = '0;
        for (int i = 0; i < DEPTH; i++) begin
            expGray[i] = 0; expGrayChk[i] = 1'b0; expDval[i] = 1'b0;
            expX[i] = 0; expY[i] = 0;
        end
        acc  = '{due: 0, mn: 255, mx: 0, sum: 0, cnt: 0, ovf: 1'b0};
        held = '{due: 0, mn: 0, mx: 0, sum: 0, cnt: 0, ovf: 1'b0};
        prevFval = 1'b0;
        modeReg  = 0;

        buildStimulus();
        if (stim.size() + 4 > DEPTH) begin
            $display("[TB] FAIL stim_depth: observed %0d, expected below %0d", stim.size(), DEPTH);
            $fatal(1, "[TB] stimulus list too long");
        end
        $display("[TB] driving %0d stimulus cycles", stim.size());

        for (int m = 0; m < stim.size(); m++) begin
            @(negedge iCLK);
            if (m > 0) begin
                expSv = 1'b0;
                if (pend.size() > 0 && pend[0].due == m) begin
                    held  = pend.pop_front();
                    expSv = 1'b1;
                end
                checkOutput("oDval", oDval, expDval[m]);
                if (expGrayChk[m]) checkOutput("oGray", oGray, expGray[m]);
                checkOutput("oX_Cont", oX_Cont, expX[m]);
                checkOutput("oY_Cont", oY_Cont, expY[m]);
                checkOutput("oStatVal", oStatVal, expSv);
                checkOutput("oMin", oMin, held.mn);
                checkOutput("oMax", oMax, held.mx);
                checkOutput("oSum", oSum, held.sum);
                checkOutput("oCount", oCount, held.cnt);
                checkOutput("oStatOvf", oStatOvf, held.ovf);
            end

            e = stim[m];
            applyStimulus(e);

            if (e.rst) begin
                // reset flushes the pipeline: three zero outputs follow
                for (int k = 1; k <= 3; k++) begin
                    expGray[m+k] = 0; expGrayChk[m+k] = 1'b1; expDval[m+k] = 1'b0;
                    expX[m+k] = 0; expY[m+k] = 0;
                end
                prevFval = 1'b0;
                modeReg  = 0;
                acc  = '{due: 0, mn: 255, mx: 0, sum: 0, cnt: 0, ovf: 1'b0};
                held = '{due: 0, mn: 0, mx: 0, sum: 0, cnt: 0, ovf: 1'b0};
                pend.delete();
            end else begin
                if (e.fval && !prevFval) modeReg = int'(e.mode);
                g = refGray(modeReg, int'(e.r), int'(e.g), int'(e.b));
                expGray[m+3]    = g;
                expGrayChk[m+3] = e.dval;
                expDval[m+3]    = e.dval;
                expX[m+3]       = int'(e.x);
                expY[m+3]       = int'(e.y);
                if (e.fval && e.dval) begin
                    if (g < acc.mn) acc.mn = g;
                    if (g > acc.mx) acc.mx = g;
                    acc.sum += g;
                    acc.cnt += 1;
                    if (acc.sum > (64'd1 << (CNT_W + OUT_W)) - 1) begin
                        acc.sum = (64'd1 << (CNT_W + OUT_W)) - 1;
                        acc.ovf = 1'b1;
                    end
                    if (acc.cnt > (64'd1 << CNT_W) - 1) begin
                        acc.cnt = (64'd1 << CNT_W) - 1;
                        acc.ovf = 1'b1;
                    end
                end
                if (!e.fval && prevFval) begin
                    acc.due = m + 4;
                    pend.push_back(acc);
                    acc = '{due: 0, mn: 255, mx: 0, sum: 0, cnt: 0, ovf: 1'b0};
                end
                prevFval = e.fval;
            end
        end

        if (pend.size() != 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL stat_pending: observed %0d, expected 0", pend.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/rgb2gray_stats.md
# rgb2gray_stats

Parametrised colour-to-gray converter, the next generation of the camera-path grayscale stage. It accepts sensor RGB pixels with frame/data valids and X/Y counters, and applies one of four weighting modes, latched per frame. It emits a rounded gray value through a fixed 3-cycle pipeline and reports per-frame statistics (min, max, sum, count) at each frame end for downstream exposure/contrast logic.

## Interface
- IN_W, 12, input colour channel width (≥ OUT_W)
- OUT_W, 8, output gray width
- CNT_W, 20, pixel counter width (800×480 fits)
- iCLK  in  1  clock; all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iMode  in  2  0=BT.601, 1=BT.709, 2=average, 3=green-only; sampled at frame start
- iRed, iGreen, iBlue  in  IN_W  pixel channels
- iDval  in  1  pixel valid
- iFval  in  1  frame valid
- iX_Cont, iY_Cont  in  16  pixel coordinates
- oGray  out  OUT_W  gray pixel
- oDval  out  1  iDval delayed 3 cycles
- oX_Cont, oY_Cont  out  16  coordinates delayed 3 cycles
- oMin, oMax  out  OUT_W  frame min/max gray
- oSum  out  CNT_W+OUT_W  frame gray sum
- oCount  out  CNT_W  frame pixel count
- oStatOvf  out  1  sum or count saturated during frame
- oStatVal  out  1  one-cycle pulse: stat outputs updated

## Operation
- Weights are 8-bit fractions summing to 256, as (R,G,B): BT.601 (77,150,29), BT.709 (54,183,19), average (85,85,86), green (0,256,0).
- Full-precision sum is S = wR·R + wG·G + wB·B, IN_W+8 bits. Gray_full = (S+128)>>8 is IN_W bits and cannot overflow. oGray = Gray_full[IN_W-1 -: OUT_W], i.e. the MSBs with truncation.
- Active mode register: reset value 0 (BT.601). It loads iMode only on a detected iFval rising edge (iFval=1, previous sample 0). Mode changes mid-frame are ignored until the next frame.
- iFval and iDval are delayed alongside the data (fval_d3, dval_d3). A pixel counts for statistics only when dval_d3 & fval_d3.
- Accumulators at frame start and after reset: min=all-ones, max=0, sum=0, count=0, ovf=0.
- Sum and count saturate at all-ones. Either saturating sets ovf.
- Frame end is fval_d3 going 1→0. On the next clock edge, accumulators copy to oMin/oMax/oSum/oCount/oStatOvf, oStatVal pulses for one cycle, and the accumulators reinitialise.
- Empty frame (no valid pixels): oStatVal still pulses, with oCount=0, oMin=all-ones, oMax=0.
- A pixel with dval_d3=1 on the cycle fval_d3=0 is outside the frame: not counted, but still output on oGray/oDval.
- Reset mid-frame: pipeline, accumulators, mode and the fval history clear, and no oStatVal is produced. If iFval is still high after reset, it reads as a rising edge, starting a new frame and latching iMode.

## Timing
- Pixel latency is 3 cycles, throughput one pixel per cycle, with no backpressure.
  - S1: register inputs and the three products.
  - S2: sum plus rounding.
  - S3: extract and register oGray, oDval, oX_Cont, oY_Cont.
- The mode latched at an iFval rise applies to the pixel presented in that same cycle.
- Statistics use the S3 values. oStatVal fires 1 cycle after fval_d3 falls, i.e. 4 cycles after the iFval falling edge at the input.
- Reset values: oGray, oDval, oX_Cont, oY_Cont, oMin, oMax, oSum, oCount, oStatOvf and oStatVal are all 0. The stat outputs hold their value between pulses.
- Back-to-back frames are legal with iFval low for ≥1 cycle. The stat pulse and the next frame's accumulation may overlap; the reinitialise-then-accumulate order is preserved.

## Structure
- Package rgb2gray_pkg holds:
  - the mode enum (MODE_BT601, MODE_BT709, MODE_AVG, MODE_GREEN);
  - per-mode weight constants;
  - the rounding constant 128.
- Sub-module frame_stats: min/max/sum/count accumulator with saturation, frame-end detect and the stat output registers. Its inputs are the S3 gray, dval_d3 and fval_d3.
- The top level holds mode latching, the multiply/sum pipeline and the coordinate delay.

## Test plan
- BT.601 with IN_W=12, OUT_W=8:
  - R=G=B=4095 → oGray=255.
  - R=4095, G=B=0 → oGray=77.
  - In both cases oDval rises exactly 3 cycles after iDval.
- Green mode, G=0xABC, R=B=0xFFF → oGray=0xAB. oX_Cont/oY_Cont equal the input coordinates delayed 3 cycles.
- Mode change mid-frame:
  - Frame starts in BT.601, iMode=2 set mid-frame → output stays BT.601 (R=4095 only → 77).
  - On the next frame (average mode), the same pixel → oGray=85.
- 4-pixel frame with gray values 10, 20, 30, 40 (green mode, G = value<<4), iFval falls → one oStatVal pulse 4 cycles later with oMin=10, oMax=40, oSum=100, oCount=4, oStatOvf=0.
- Frame with iFval pulsed and no iDval → oStatVal pulse with oCount=0, oMin=255, oMax=0, oSum=0.
- iReset asserted mid-frame for 1 cycle with iFval held high:
  - No oStatVal for the aborted frame; all outputs are 0 the cycle after reset.
  - The following frame end reports only pixels presented after reset.
